// File: rtl/conv_frame_ctrl_if.sv
// Handshake and status bundle between the frame controller and its upstream source / encoder sink.
// The master side drives requests and data; the slave side is the controller.
interface conv_frame_ctrl_if #(
    parameter int CW = 5
);
    logic          start_sig;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          out_ready;
    logic          enc_clr;
    logic          enc_en;
    logic          enc_bit;
    logic [CW-1:0] counter_sig;
    logic          busy;
    logic          done_sig;

    modport master (
        output start_sig, in_valid, in_bit, out_ready,
        input  in_ready, enc_clr, enc_en, enc_bit, counter_sig, busy, done_sig
    );

    modport slave (
        input  start_sig, in_valid, in_bit, out_ready,
        output in_ready, enc_clr, enc_en, enc_bit, counter_sig, busy, done_sig
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Convolutional encoder frame controller: clears the encoder, shifts FRAME_LEN data bits,
// then flushes it with CONSTRAINT_LEN-1 zero tail bits before pulsing done.
module conv_frame_ctrl #(
    parameter int FRAME_LEN      = 16,
    parameter int CONSTRAINT_LEN = 3
) (
    input  logic              clk_sig,
    input  logic              reset_sig,
    conv_frame_ctrl_if.slave  bus
);
    localparam int LAST_IDX = FRAME_LEN + CONSTRAINT_LEN - 2;
    localparam int CW       = (LAST_IDX + 1 > 1) ? $clog2(LAST_IDX + 1) : 1;
    localparam logic [CW-1:0] DATA_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(LAST_IDX);
    localparam bit HAS_TAIL = (CONSTRAINT_LEN > 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DATA,
        TAIL,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic          shift;
    logic          ready;
    logic          shift_bit;

    // The final shift of a frame reloads the counter with zero so it never passes LAST_IDX.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        shift     = 1'b0;
        ready     = 1'b0;
        shift_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_sig) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                counter_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                ready = bus.out_ready;
                if (bus.in_valid && bus.out_ready) begin
                    shift     = 1'b1;
                    shift_bit = bus.in_bit;
                    if (counter_q == DATA_LAST) begin
                        if (HAS_TAIL) begin
                            counter_d = counter_q + CW'(1);
                            state_d   = TAIL;
                        end else begin
                            counter_d = '0;
                            state_d   = DONE;
                        end
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            TAIL: begin
                shift = bus.out_ready;
                if (bus.out_ready) begin
                    if (counter_q == TAIL_LAST) begin
                        counter_d = '0;
                        state_d   = DONE;
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            DONE: begin
                counter_d = '0;
                state_d   = IDLE;
            end
            default: begin
                counter_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q   <= IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.enc_en      = shift;
    assign bus.enc_bit     = shift_bit;
    assign bus.enc_clr     = (state_q == CLEAR);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done_sig    = (state_q == DONE);
    assign bus.counter_sig = counter_q;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl: default 16/3 frame plus a minimal 1/1 instance.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
module tb_conv_frame_ctrl;
    logic clk_sig   = 1'b0;
    logic reset_sig = 1'b1;
    int   passed    = 0;
    int   total     = 0;

    conv_frame_ctrl_if #(.CW(5)) bus ();
    conv_frame_ctrl_if #(.CW(1)) bus_min ();

    conv_frame_ctrl #(.FRAME_LEN(16), .CONSTRAINT_LEN(3)) dut (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .bus       (bus)
    );

    conv_frame_ctrl #(.FRAME_LEN(1), .CONSTRAINT_LEN(1)) dut_min (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .bus       (bus_min)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic drive(input logic st, input logic v, input logic b, input logic r);
        @(negedge clk_sig);
        bus.start_sig     = st;
        bus.in_valid      = v;
        bus.in_bit        = b;
        bus.out_ready     = r;
        bus_min.start_sig = st;
        bus_min.in_valid  = v;
        bus_min.in_bit    = b;
        bus_min.out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        bit seen_done;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if ({bus.in_ready, bus.enc_en, bus.enc_bit, bus.enc_clr, bus.busy, bus.done_sig} !== 6'b0)
            $display("FAIL reset_outputs got %b want 000000",
                     {bus.in_ready, bus.enc_en, bus.enc_bit, bus.enc_clr, bus.busy, bus.done_sig});
        else passed++;
        total++;
        if (bus.counter_sig !== 5'd0) $display("FAIL reset_counter got %0d want 0", bus.counter_sig);
        else passed++;
        // Release reset with start already high: the very next rising edge must launch CLEAR.
        @(negedge clk_sig);
        reset_sig = 1'b0;
        #1;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if ({bus.enc_clr, bus.busy} !== 2'b11)
            $display("FAIL reset_first_start got clr/busy=%b want 11", {bus.enc_clr, bus.busy});
        else passed++;
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 40) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.done_sig === 1'b1) seen_done = 1'b1;
            cyc++;
        end
        total++;
        if (!seen_done) $display("FAIL reset_drain got no done in 40 cycles want done");
        else passed++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_full_frame(input string name, input bit poke_start);
        logic [15:0] pat = 16'hA5C3;
        int n_en = 0;
        int n_done = 0;
        for (int cyc = 0; cyc <= 23; cyc++) begin
            logic st, b, e_clr, e_en, e_bit, e_done, e_busy, e_rdy;
            int e_cnt;
            st = (cyc == 0) || (poke_start && (cyc == 8 || cyc == 18 || cyc == 20));
            b  = (cyc >= 2 && cyc <= 17) ? pat[cyc-2] : 1'b1;
            drive(st, 1'b1, b, 1'b1);
            e_clr  = (cyc == 1);
            e_en   = (cyc >= 2 && cyc <= 19);
            e_bit  = (cyc >= 2 && cyc <= 17) ? b : 1'b0;
            e_rdy  = (cyc >= 2 && cyc <= 17);
            e_done = (cyc == 20);
            e_busy = (cyc >= 1 && cyc <= 20);
            e_cnt  = (cyc >= 2 && cyc <= 19) ? cyc - 2 : 0;
            total++;
            if ({bus.enc_clr, bus.enc_en, bus.enc_bit, bus.done_sig, bus.busy, bus.in_ready} !==
                {e_clr, e_en, e_bit, e_done, e_busy, e_rdy})
                $display("FAIL %s cyc%0d clr/en/bit/done/busy/rdy got %b want %b", name, cyc,
                         {bus.enc_clr, bus.enc_en, bus.enc_bit, bus.done_sig, bus.busy, bus.in_ready},
                         {e_clr, e_en, e_bit, e_done, e_busy, e_rdy});
            else passed++;
            total++;
            if (bus.counter_sig !== 5'(e_cnt))
                $display("FAIL %s_counter cyc%0d got %0d want %0d", name, cyc, bus.counter_sig, e_cnt);
            else passed++;
            if (bus.enc_en === 1'b1) n_en++;
            if (bus.done_sig === 1'b1) n_done++;
        end
        total++;
        if (n_en != 18) $display("FAIL %s_shift_count got %0d want 18", name, n_en);
        else passed++;
        total++;
        if (n_done != 1) $display("FAIL %s_done_count got %0d want 1", name, n_done);
        else passed++;
    endtask

    task automatic test_basic();
        check_full_frame("basic", 1'b0);
    endtask

    task automatic test_gaps();
        logic [15:0] pat = 16'h3C96;
        int n_en = 0;
        int n_done = 0;
        for (int cyc = 0; cyc <= 37; cyc++) begin
            logic data, acc_cyc, v, b, e_en, e_bit, e_done, e_busy;
            int k, e_cnt;
            k       = cyc - 2;
            data    = (cyc >= 2 && cyc <= 32);
            acc_cyc = data && (k % 2 == 0);
            v       = data ? acc_cyc : 1'b1;
            b       = acc_cyc ? pat[k/2] : 1'b1;
            drive(cyc == 0, v, b, 1'b1);
            e_en   = acc_cyc || cyc == 33 || cyc == 34;
            e_bit  = acc_cyc ? pat[k/2] : 1'b0;
            e_done = (cyc == 35);
            e_busy = (cyc >= 1 && cyc <= 35);
            e_cnt  = data ? (k + 1) / 2 : (cyc == 33) ? 16 : (cyc == 34) ? 17 : 0;
            total++;
            if ({bus.enc_en, bus.enc_bit, bus.done_sig, bus.busy} !== {e_en, e_bit, e_done, e_busy})
                $display("FAIL gaps cyc%0d en/bit/done/busy got %b want %b", cyc,
                         {bus.enc_en, bus.enc_bit, bus.done_sig, bus.busy}, {e_en, e_bit, e_done, e_busy});
            else passed++;
            total++;
            if (bus.counter_sig !== 5'(e_cnt))
                $display("FAIL gaps_counter cyc%0d got %0d want %0d", cyc, bus.counter_sig, e_cnt);
            else passed++;
            if (bus.enc_en === 1'b1) n_en++;
            if (bus.done_sig === 1'b1) n_done++;
        end
        total++;
        if (n_en != 18) $display("FAIL gaps_shift_count got %0d want 18", n_en);
        else passed++;
        total++;
        if (n_done != 1) $display("FAIL gaps_done_count got %0d want 1", n_done);
        else passed++;
    endtask

    task automatic test_stall();
        logic [15:0] pat = 16'h5A0F;
        int n_en = 0;
        int n_done = 0;
        for (int cyc = 0; cyc <= 30; cyc++) begin
            logic data, r, b, e_en, e_bit, e_rdy, e_done, e_busy;
            int acc, e_cnt;
            r    = !((cyc >= 6 && cyc <= 10) || (cyc >= 23 && cyc <= 25));
            data = (cyc >= 2 && cyc <= 22);
            acc  = (cyc <= 6) ? cyc - 2 : (cyc <= 10) ? 4 : cyc - 7;
            b    = data ? pat[acc] : 1'b1;
            drive(cyc == 0, 1'b1, b, r);
            e_en   = (data && r) || cyc == 26 || cyc == 27;
            e_rdy  = data && r;
            e_bit  = (data && r) ? pat[acc] : 1'b0;
            e_done = (cyc == 28);
            e_busy = (cyc >= 1 && cyc <= 28);
            e_cnt  = data ? acc : (cyc >= 23 && cyc <= 26) ? 16 : (cyc == 27) ? 17 : 0;
            total++;
            if ({bus.enc_en, bus.enc_bit, bus.in_ready, bus.done_sig, bus.busy} !==
                {e_en, e_bit, e_rdy, e_done, e_busy})
                $display("FAIL stall cyc%0d en/bit/rdy/done/busy got %b want %b", cyc,
                         {bus.enc_en, bus.enc_bit, bus.in_ready, bus.done_sig, bus.busy},
                         {e_en, e_bit, e_rdy, e_done, e_busy});
            else passed++;
            total++;
            if (bus.counter_sig !== 5'(e_cnt))
                $display("FAIL stall_counter cyc%0d got %0d want %0d", cyc, bus.counter_sig, e_cnt);
            else passed++;
            if (bus.enc_en === 1'b1) n_en++;
            if (bus.done_sig === 1'b1) n_done++;
        end
        total++;
        if (n_en != 18) $display("FAIL stall_shift_count got %0d want 18", n_en);
        else passed++;
        total++;
        if (n_done != 1) $display("FAIL stall_done_count got %0d want 1", n_done);
        else passed++;
    endtask

    task automatic test_start_ignored();
        check_full_frame("start_ignored", 1'b1);
    endtask

    task automatic test_reset_midframe();
        for (int cyc = 0; cyc <= 9; cyc++) drive(cyc == 0, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.counter_sig !== 5'd7) $display("FAIL midreset_pre_counter got %0d want 7", bus.counter_sig);
        else passed++;
        reset_sig = 1'b1;
        #1;
        total++;
        if ({bus.in_ready, bus.enc_en, bus.enc_bit, bus.enc_clr, bus.busy, bus.done_sig} !== 6'b0)
            $display("FAIL midreset_outputs got %b want 000000",
                     {bus.in_ready, bus.enc_en, bus.enc_bit, bus.enc_clr, bus.busy, bus.done_sig});
        else passed++;
        total++;
        if (bus.counter_sig !== 5'd0) $display("FAIL midreset_counter got %0d want 0", bus.counter_sig);
        else passed++;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk_sig);
        reset_sig = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1);
            total++;
            if ({bus.busy, bus.done_sig, bus.enc_en} !== 3'b000)
                $display("FAIL midreset_idle cyc%0d busy/done/en got %b want 000", cyc,
                         {bus.busy, bus.done_sig, bus.enc_en});
            else passed++;
        end
        check_full_frame("restart", 1'b0);
    endtask

    task automatic test_min_frame();
        logic [4:0] exp_vec [0:5];
        logic       valid_vec [0:5];
        exp_vec   = '{5'b00000, 5'b10001, 5'b00001, 5'b01101, 5'b00011, 5'b00000};
        valid_vec = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int cyc = 0; cyc <= 5; cyc++) begin
            drive(cyc == 0, valid_vec[cyc], 1'b1, 1'b1);
            total++;
            if ({bus_min.enc_clr, bus_min.enc_en, bus_min.enc_bit, bus_min.done_sig, bus_min.busy} !==
                exp_vec[cyc])
                $display("FAIL min_frame cyc%0d clr/en/bit/done/busy got %b want %b", cyc,
                         {bus_min.enc_clr, bus_min.enc_en, bus_min.enc_bit, bus_min.done_sig, bus_min.busy},
                         exp_vec[cyc]);
            else passed++;
            total++;
            if (bus_min.counter_sig !== 1'b0)
                $display("FAIL min_counter cyc%0d got %0d want 0", cyc, bus_min.counter_sig);
            else passed++;
        end
    endtask

    initial begin
        bus.start_sig     = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_bit        = 1'b0;
        bus.out_ready     = 1'b0;
        bus_min.start_sig = 1'b0;
        bus_min.in_valid  = 1'b0;
        bus_min.in_bit    = 1'b0;
        bus_min.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_stall();
        test_start_ignored();
        test_reset_midframe();
        test_min_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 16, number of information bits per frame (>=1).
REQ-002 Parameter CONSTRAINT_LEN, default 3, encoder constraint length K; tail length is K-1 zero bits (>=1).
REQ-003 Localparam CW = max(1, ceil(log2(FRAME_LEN+CONSTRAINT_LEN-1))), counter width.
REQ-004 clk_sig  in  1  single clock; all state changes on rising edge.
REQ-005 reset_sig  in  1  asynchronous, active-high reset.
REQ-006 start_sig  in  1  frame start request, sampled only in IDLE.
REQ-007 in_valid  in  1  upstream information bit valid.
REQ-008 in_bit  in  1  upstream information bit.
REQ-009 in_ready  out  1  controller accepts in_bit this cycle.
REQ-010 out_ready  in  1  downstream encoder/sink can take a shift this cycle.
REQ-011 enc_clr  out  1  clears encoder shift register.
REQ-012 enc_en  out  1  encoder shift enable.
REQ-013 enc_bit  out  1  bit shifted into encoder.
REQ-014 counter_sig  out  CW  index of bits shifted in the current frame.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done_sig  out  1  one-cycle pulse at frame end.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, DATA, TAIL, DONE.
REQ-018 IDLE: start_sig=1 -> CLEAR; otherwise stay; in_ready=0, enc_en=0.
REQ-019 CLEAR: enc_clr=1 for exactly one cycle, counter_sig loaded 0, unconditional -> DATA.
REQ-020 DATA: in_ready=out_ready (combinational); transfer = in_valid & in_ready.
REQ-021 DATA transfer: enc_en=1, enc_bit=in_bit, counter_sig increments by 1 on the edge.
REQ-022 DATA without transfer: enc_en=0, enc_bit=0, counter_sig holds; no timeout.
REQ-023 Transfer with counter_sig==FRAME_LEN-1 -> TAIL.
REQ-024 TAIL: in_ready=0, enc_bit=0, enc_en=out_ready; counter_sig increments on each enc_en.
REQ-025 TAIL shift with counter_sig==FRAME_LEN+K-2 -> DONE; exactly K-1 tail shifts per frame.
REQ-026 DONE: done_sig=1 one cycle, counter_sig cleared to 0, -> IDLE unconditionally.
REQ-027 start_sig outside IDLE SHALL be ignored (not queued).
REQ-028 enc_en, enc_bit, in_ready combinational from state and handshake; busy, done_sig, enc_clr, counter_sig decoded from registered state/counter only.
REQ-029 counter_sig SHALL never exceed FRAME_LEN+K-2; no wrap within a frame.
REQ-030 Total enc_en pulses per frame SHALL equal FRAME_LEN+K-1 regardless of stalls.

Reset
REQ-031 reset_sig=1 SHALL immediately force IDLE, counter_sig=0, busy=0, done_sig=0, enc_clr=0, enc_en=0, in_ready=0, enc_bit=0.
REQ-032 Reset mid-frame SHALL abort the frame with no done_sig; next frame requires a new start_sig and re-runs CLEAR.
REQ-033 First start_sig sampled on the first rising edge after reset_sig deasserts.

Verification (FRAME_LEN=16, K=3)
REQ-034 start pulse at edge 0, in_valid=out_ready=1 -> enc_clr cycle 1, enc_en cycles 2-19 (16 data then 2 zeros), done_sig cycle 20, busy low cycle 21.
REQ-035 in_valid low every other cycle -> exactly 16 data shifts, enc_bit matches accepted in_bit order, counter_sig holds during gaps.
REQ-036 out_ready=0 for 5 cycles in DATA and 3 in TAIL -> in_ready=0, enc_en=0 during stall, total enc_en still 18, done_sig once.
REQ-037 reset_sig asserted at counter_sig=7 -> all outputs 0 same cycle, no done_sig; restart yields full 18-shift frame starting at counter 0.
REQ-038 start_sig pulsed during DATA and TAIL -> ignored; only one frame and one done_sig.
REQ-039 FRAME_LEN=1, K=1 -> CLEAR, one data shift, DONE; counter_sig width 1, no TAIL cycle.
